// File: rtl/mem_access_if.sv
// Request/response and data-RAM signal bundle for the MEM-stage load/store unit.
// The slave modport is the unit. The master modport is the pipeline requester together with the RAM.
interface mem_access_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ram_en;
    logic [3:0]        ram_wen;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_en, ram_wen, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_en, ram_wen, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder that serves one request at a time against a byte-enabled, fixed-latency data RAM.
// It produces the byte strobes and replicated store data, and aligns and extends load data.
module mem_access_unit #(
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst_n,
    mem_access_if.slave   bus
);
    localparam logic [1:0] RAM_B = 2'b00;
    localparam logic [1:0] RAM_H = 2'b01;
    localparam logic [1:0] RAM_W = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              latch, capture, issue;

    logic              we_p0, sgn_p0;
    logic [1:0]        size_p0, off_p0;
    logic [31:0]       wdata_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       rdata_p1;
    logic              unused_addr_hi;

    function automatic logic is_bad(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) || (size == RAM_H && off[0]) || (size == RAM_W && off != 2'b00);
    endfunction

    function automatic logic [3:0] strobe(input logic [1:0] size, input logic [1:0] off);
        case (size)
            RAM_B:   return 4'b0001 << off;
            RAM_H:   return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] w);
        case (size)
            RAM_B:   return {4{w[7:0]}};
            RAM_H:   return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] size, input logic sgn,
                                             input logic [1:0] off, input logic [31:0] w);
        logic [31:0]        lane;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] r;
        lane = w >> {off, 3'b000};
        sb   = lane[7:0];
        sh   = lane[15:0];
        case (size)
            RAM_B: begin
                r = sb;
                return sgn ? r : {24'b0, lane[7:0]};
            end
            RAM_H: begin
                r = sh;
                return sgn ? r : {16'b0, lane[15:0]};
            end
            default: return w;
        endcase
    endfunction

    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch   = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: if (bus.req_valid) begin
                latch   = 1'b1;
                state_d = is_bad(bus.req_size, bus.req_addr[1:0]) ? S_ERR : S_ISSUE;
            end
            S_ISSUE: if (we_p0) begin
                state_d = S_DONE;
            end else begin
                state_d = S_WAIT;
                cnt_d   = 2'(RD_LAT - 1);
            end
            S_WAIT: if (cnt_q == 2'd0) begin
                capture = 1'b1;
                state_d = S_DONE;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields latched at handshake
    always_ff @(posedge cpu_clk) begin
        if (latch) begin
            we_p0    <= bus.req_we;
            size_p0  <= bus.req_size;
            sgn_p0   <= bus.req_signed;
            off_p0   <= bus.req_addr[1:0];
            wdata_p0 <= bus.req_wdata;
            addr_p0  <= bus.req_addr[ADDR_W+1:2];
        end
    end

    // Load data captured on the cycle the RAM output is valid
    always_ff @(posedge cpu_clk) begin
        if (capture) rdata_p1 <= load_ext(size_p0, sgn_p0, off_p0, bus.ram_rdata);
    end

    assign issue          = (state_q == S_ISSUE);
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.ram_en     = issue;
    assign bus.ram_addr   = issue ? addr_p0 : '0;
    assign bus.ram_wen    = (issue && we_p0) ? strobe(size_p0, off_p0) : 4'b0000;
    assign bus.ram_wdata  = (issue && we_p0) ? store_rep(size_p0, wdata_p0) : 32'b0;
    assign bus.resp_valid = (state_q == S_DONE) || (state_q == S_ERR);
    assign bus.resp_err   = (state_q == S_ERR);
    assign bus.resp_rdata = (state_q == S_DONE && !we_p0) ? rdata_p1 : 32'b0;
endmodule
